ili9341_spi_tx: RTL and testbench

Byte-level SPI transmitter for the ILI9341 panel, fed by the init/loop command sequencer. It accepts one 8-bit command or data byte plus its D/C flag per handshake. It serialises the byte MSB-first in SPI mode 0 (SCK idle low, MOSI set up on the falling edge, sampled by the panel on the rising edge). It drives CS and D/C and pulses `done` when the byte has left the wire.

---
 rtl/ili9341_spi_tx.sv | 154 +++++++++++++++
 tb/tb_ili9341_spi_tx.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ili9341_spi_tx.sv
// Byte-level SPI transmitter for the ILI9341 panel.
// Accepts one command/data byte plus D/C flag per handshake and shifts it
// out MSB-first in SPI mode 0, framed by chip select, then pulses done.
// Every output comes straight from a flop; next values are formed in one
// combinational process and captured by one register process.

module ili9341_spi_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       dc,
  output logic       ready,
  output logic       done,
  output logic       spi_sck,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       spi_dc
);

  // Phase counter is at least one bit wide even when CLK_DIV is 1.
  localparam int              PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0]   PHASE_ZERO = PW'(0);
  localparam logic [PW-1:0]   PHASE_ONE  = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   phase_r, phase_s;
  logic [2:0]      bit_r, bit_s;
  logic [7:0]      shift_r, shift_s;
  logic            ready_r, ready_s;
  logic            done_r, done_s;
  logic            sck_r, sck_s;
  logic            cs_n_r, cs_n_s;
  logic            dc_r, dc_s;
  logic            phase_last_s;

  // Next-state and next-output logic for the IDLE -> SHIFT -> HOLD frame.
  always_comb begin
    state_s      = state_r;
    phase_s      = phase_r;
    bit_s        = bit_r;
    shift_s      = shift_r;
    ready_s      = ready_r;
    done_s       = 1'b0;
    sck_s        = sck_r;
    cs_n_s       = cs_n_r;
    dc_s         = dc_r;
    phase_last_s = (phase_r == PHASE_LAST);

    case (state_r)
      ST_IDLE: begin
        if (load) begin
          // Latch the byte and D/C together; D/C setup equals CS setup.
          shift_s = data;
          dc_s    = dc;
          cs_n_s  = 1'b0;
          ready_s = 1'b0;
          sck_s   = 1'b0;
          phase_s = PHASE_ZERO;
          bit_s   = 3'd0;
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (phase_last_s) begin
          phase_s = PHASE_ZERO;
          if (!sck_r) begin
            sck_s = 1'b1;
          end else begin
            sck_s = 1'b0;
            if (bit_r == 3'd7) begin
              // Last falling edge: keep MOSI on bit 0 through HOLD.
              state_s = ST_HOLD;
            end else begin
              bit_s   = bit_r + 3'd1;
              shift_s = {shift_r[6:0], 1'b0};
            end
          end
        end else begin
          phase_s = phase_r + PHASE_ONE;
        end
      end

      ST_HOLD: begin
        if (phase_last_s) begin
          phase_s = PHASE_ZERO;
          bit_s   = 3'd0;
          shift_s = 8'h00;
          cs_n_s  = 1'b1;
          ready_s = 1'b1;
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          phase_s = phase_r + PHASE_ONE;
        end
      end

      default: begin
        state_s = ST_IDLE;
        phase_s = PHASE_ZERO;
        bit_s   = 3'd0;
        shift_s = 8'h00;
        sck_s   = 1'b0;
        cs_n_s  = 1'b1;
        ready_s = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      phase_r <= PHASE_ZERO;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      sck_r   <= 1'b0;
      cs_n_r  <= 1'b1;
      dc_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      phase_r <= phase_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      ready_r <= ready_s;
      done_r  <= done_s;
      sck_r   <= sck_s;
      cs_n_r  <= cs_n_s;
      dc_r    <= dc_s;
    end
  end

  assign ready    = ready_r;
  assign done     = done_r;
  assign spi_sck  = sck_r;
  assign spi_mosi = shift_r[7];
  assign spi_cs_n = cs_n_r;
  assign spi_dc   = dc_r;

endmodule

// File: tb/tb_ili9341_spi_tx.sv
// Self-checking bench for ili9341_spi_tx. Three instances run with
// CLK_DIV = 2, 1 and 3. Expected waveforms come from the closed-form frame
// timing; a wire-level monitor decodes MOSI/DC on SCK rising edges and is
// compared with the list of bytes that were sent.

module tb_ili9341_spi_tx;

  logic       clk;
  logic       rst;
  logic [2:0] load;
  logic [7:0] data_in [3];
  logic [2:0] dc_in;
  logic [2:0] ready;
  logic [2:0] done;
  logic [2:0] sck;
  logic [2:0] mosi;
  logic [2:0] cs_n;
  logic [2:0] dc_out;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp0[$], exp1[$], exp2[$];
  logic [8:0] dec0[$], dec1[$], dec2[$];
  int         exp_done [3];
  int         done_cnt [3];
  int         nbits    [3];
  logic [7:0] acc      [3];
  logic       psck     [3];

  ili9341_spi_tx #(.CLK_DIV(2)) u_d2 (
    .clk(clk), .rst(rst), .load(load[0]), .data(data_in[0]), .dc(dc_in[0]),
    .ready(ready[0]), .done(done[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]),
    .spi_cs_n(cs_n[0]), .spi_dc(dc_out[0]));

  ili9341_spi_tx #(.CLK_DIV(1)) u_d1 (
    .clk(clk), .rst(rst), .load(load[1]), .data(data_in[1]), .dc(dc_in[1]),
    .ready(ready[1]), .done(done[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]),
    .spi_cs_n(cs_n[1]), .spi_dc(dc_out[1]));

  ili9341_spi_tx #(.CLK_DIV(3)) u_d3 (
    .clk(clk), .rst(rst), .load(load[2]), .data(data_in[2]), .dc(dc_in[2]),
    .ready(ready[2]), .done(done[2]), .spi_sck(sck[2]), .spi_mosi(mosi[2]),
    .spi_cs_n(cs_n[2]), .spi_dc(dc_out[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Wire-level decoder: what the panel would see on each SCK rising edge.
  always @(posedge clk) begin
    #1;
    for (int u = 0; u < 3; u++) begin
      if (cs_n[u]) begin
        nbits[u] = 0;
      end else if (sck[u] && !psck[u]) begin
        acc[u]   = {acc[u][6:0], mosi[u]};
        nbits[u] = nbits[u] + 1;
        if (nbits[u] == 8) begin
          case (u)
            0: dec0.push_back({dc_out[u], acc[u]});
            1: dec1.push_back({dc_out[u], acc[u]});
            default: dec2.push_back({dc_out[u], acc[u]});
          endcase
          nbits[u] = 0;
        end
      end
      psck[u] = sck[u];
      if (done[u]) done_cnt[u] = done_cnt[u] + 1;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Send one byte from a ready cycle and check every cycle k = 0..17D.
  // With junk set, load stays high and data/dc keep changing mid-frame.
  task automatic check_frame(input int u, input int d, input logic [7:0] b,
                             input logic f, input bit junk);
    logic [5:0] obs, expv;
    logic       e_sck, e_mosi, e_cs, e_end;
    int         rises;
    logic       prev;
    total++;
    if (ready[u] !== 1'b1) begin
      bad++;
      $display("FAIL ready_before_load u=%0d got=%b want=1", u, ready[u]);
    end
    load[u] = 1'b1; data_in[u] = b; dc_in[u] = f;
    step();
    if (!junk) load[u] = 1'b0;
    rises = 0;
    prev  = 1'b0;
    for (int k = 0; k <= 17 * d; k++) begin
      e_end  = (k == 17 * d);
      e_cs   = e_end;
      e_sck  = (k < 16 * d) && (((k / d) % 2) == 1);
      e_mosi = (k < 16 * d) ? b[7 - k / (2 * d)] : ((k < 17 * d) ? b[0] : 1'b0);
      expv   = {e_cs, e_sck, e_mosi, f, e_end, e_end};
      obs    = {cs_n[u], sck[u], mosi[u], dc_out[u], ready[u], done[u]};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("FAIL frame u=%0d byte=%h k=%0d {cs_n,sck,mosi,dc,ready,done} got=%b want=%b",
                 u, b, k, obs, expv);
      end
      if (sck[u] && !prev) rises++;
      prev = sck[u];
      if (junk) begin
        data_in[u] = (k % 2 == 1) ? 8'hFF : 8'h00;
        dc_in[u]   = ~dc_in[u];
      end
      if (k < 17 * d) step();
    end
    load[u] = 1'b0;
    total++;
    if (rises !== 8) begin
      bad++;
      $display("FAIL sck_rises u=%0d byte=%h got=%0d want=8", u, b, rises);
    end
    exp_done[u] = exp_done[u] + 1;
    case (u)
      0: exp0.push_back({f, b});
      1: exp1.push_back({f, b});
      default: exp2.push_back({f, b});
    endcase
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(); step();
    for (int u = 0; u < 3; u++) begin
      total++;
      if ({ready[u], done[u], sck[u], mosi[u], cs_n[u], dc_out[u]} !== 6'b100010) begin
        bad++;
        $display("FAIL reset_values u=%0d got=%b want=100010", u,
                 {ready[u], done[u], sck[u], mosi[u], cs_n[u], dc_out[u]});
      end
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic;
    check_frame(0, 2, 8'hCB, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    check_frame(0, 2, 8'h39, 1'b1, 1'b0);
    check_frame(0, 2, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic test_hold_load;
    check_frame(0, 2, 8'hA5, 1'b0, 1'b1);
    check_frame(0, 2, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset;
    load[0] = 1'b1; data_in[0] = 8'hFF; dc_in[0] = 1'b1;
    step();
    load[0] = 1'b0;
    for (int k = 0; k < 10; k++) step();
    total++;
    if (cs_n[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_frame_cs u=0 got=%b want=0", cs_n[0]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({ready[0], done[0], sck[0], mosi[0], cs_n[0], dc_out[0]} !== 6'b100010) begin
      bad++;
      $display("FAIL mid_reset u=0 got=%b want=100010",
               {ready[0], done[0], sck[0], mosi[0], cs_n[0], dc_out[0]});
    end
    for (int k = 0; k < 40; k++) begin
      step();
      total++;
      if (done[0] !== 1'b0 || cs_n[0] !== 1'b1) begin
        bad++;
        $display("FAIL after_reset u=0 k=%0d done=%b cs_n=%b want done=0 cs_n=1",
                 k, done[0], cs_n[0]);
      end
    end
  endtask

  task automatic test_div1;
    check_frame(1, 1, 8'h80, 1'b0, 1'b0);
    check_frame(1, 1, 8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      check_frame(1, 1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic test_stream;
    logic [8:0] entry;
    for (int i = 0; i < 48; i++) begin
      entry = 9'($urandom_range(0, 511));
      check_frame(2, 3, entry[7:0], entry[8], 1'b0);
    end
    step(); step();
    total++;
    if (done_cnt[2] !== 48) begin
      bad++;
      $display("FAIL stream_done_count got=%0d want=48", done_cnt[2]);
    end
  endtask

  task automatic test_scoreboard;
    logic [8:0] e[$];
    logic [8:0] g[$];
    step(); step();
    for (int u = 0; u < 3; u++) begin
      case (u)
        0: begin e = exp0; g = dec0; end
        1: begin e = exp1; g = dec1; end
        default: begin e = exp2; g = dec2; end
      endcase
      total++;
      if (g.size() !== e.size()) begin
        bad++;
        $display("FAIL decoded_count u=%0d got=%0d want=%0d", u, g.size(), e.size());
      end
      for (int i = 0; i < e.size() && i < g.size(); i++) begin
        total++;
        if (g[i] !== e[i]) begin
          bad++;
          $display("FAIL decoded_byte u=%0d idx=%0d got=%h want=%h", u, i, g[i], e[i]);
        end
      end
      total++;
      if (done_cnt[u] !== exp_done[u]) begin
        bad++;
        $display("FAIL done_pulses u=%0d got=%0d want=%0d", u, done_cnt[u], exp_done[u]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    load = 3'b000;
    dc_in = 3'b000;
    for (int u = 0; u < 3; u++) begin
      data_in[u]  = 8'h00;
      exp_done[u] = 0;
      done_cnt[u] = 0;
      nbits[u]    = 0;
      acc[u]      = 8'h00;
      psck[u]     = 1'b0;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold_load();
    test_mid_reset();
    test_div1();
    test_stream();
    test_scoreboard();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
